// File: rtl/uart_tx.sv
// Buffered UART transmitter: a small byte FIFO feeding an 8N1-style serialiser,
// plus a BREAK generator that drives the line low for one full frame time.
module uart_tx #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50000000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0]       uart_tx_data,
    input  logic                          uart_tx_valid,
    output logic                          uart_tx_ready,
    input  logic                          uart_tx_break,
    output logic                          uart_txd,
    output logic                          uart_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(CPB * (1 + PAYLOAD_BITS + STOP_BITS) + 1);
    localparam int BW  = $clog2(PAYLOAD_BITS + 1);

    localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CPB - 1);
    localparam logic [CW-1:0] BRK_END  = CW'(CPB * (1 + PAYLOAD_BITS + STOP_BITS) - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]             count_q, count_d;
    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic                    brk_pend_q, brk_pend_d;
    logic                    brk_hi_q, brk_hi_d;
    logic                    txd_q, txd_d;
    logic                    push, pop;

    assign uart_tx_ready = (count_q != FULL_CNT);
    assign push          = uart_tx_valid && uart_tx_ready;
    assign uart_txd      = txd_q;
    assign uart_tx_busy  = (state_q != S_IDLE);
    assign fifo_count    = count_q;

    // Storage is not reset; flushing is done by clearing pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= uart_tx_data;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        brk_hi_d   = brk_hi_q;
        brk_pend_d = brk_pend_q | uart_tx_break;
        pop        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (uart_tx_en && brk_pend_q) begin
                    state_d    = S_BREAK;
                    brk_hi_d   = 1'b0;
                    brk_pend_d = 1'b0;
                end else if (uart_tx_en && count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == BIT_END) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    if (bit_q == LAST_BIT) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == STOP_END) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_BREAK: begin
                // Low for a whole frame time, then a stop-length high mark.
                if (!brk_hi_q && cnt_q == BRK_END) begin
                    brk_hi_d = 1'b1;
                    cnt_d    = '0;
                end else if (brk_hi_q && cnt_q == STOP_END) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Line value follows the next state so it changes on the transition edge.
        unique case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            S_BREAK: txd_d = brk_hi_d;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            brk_pend_q <= 1'b0;
            brk_hi_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            brk_pend_q <= brk_pend_d;
            brk_hi_q   <= brk_hi_d;
            txd_q      <= txd_d;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at CPB=10: directed stimulus queues expected
// frames/BREAKs; a line monitor decodes uart_txd and checks content and spacing.
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_break = 1'b0;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         brk;
        logic [7:0] data;
        int         gap;
    } exp_t;
    exp_t exp_q[$];

    uart_tx #(
        .BIT_RATE(100), .CLK_HZ(1000), .PAYLOAD_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .uart_tx_en(en), .uart_tx_data(tx_data),
        .uart_tx_valid(tx_valid), .uart_tx_ready(tx_ready), .uart_tx_break(tx_break),
        .uart_txd(txd), .uart_tx_busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic expect_item(input bit brk, input logic [7:0] d, input int gap);
        exp_t e;
        e.brk = brk; e.data = d; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // ---------------- line monitor ----------------
    int         cyc = 0;
    bit         m_active = 0;
    bit         m_brk = 0;
    int         m_cnt = 0;
    int         m_low = 0;
    int         t_start = 0;
    int         prev_start = 0;
    bit         prev_valid = 0;
    logic [7:0] m_data = '0;

    task automatic mon_finish(input bit is_brk);
        exp_t e;
        m_active = 0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_item: got brk=%0d data=%0h expected nothing", is_brk, m_data);
        end else begin
            e = exp_q.pop_front();
            chk("mon_kind_is_break", 32'(is_brk), 32'(e.brk));
            if (!is_brk) chk("mon_frame_data", 32'(m_data), 32'(e.data));
            else         chk("mon_break_low_cycles", 32'(m_low), 32'd100);
            if (e.gap >= 0 && prev_valid) chk("mon_start_spacing", 32'(t_start - prev_start), 32'(e.gap));
        end
        prev_start = t_start;
        prev_valid = 1;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_active   = 0;
            prev_valid = 0;
        end else if (!m_active) begin
            if (txd === 1'b0) begin
                m_active = 1; m_brk = 0; m_cnt = 0; m_low = 1; t_start = cyc; m_data = '0;
            end
        end else begin
            m_cnt++;
            if (txd === 1'b0) m_low++;
            if (!m_brk) begin
                if (m_cnt == 5) chk("mon_start_bit", 32'(txd), 32'd0);
                if (m_cnt >= 15 && m_cnt <= 85 && (m_cnt % 10) == 5) m_data[(m_cnt - 15) / 10] = txd;
                if (m_cnt == 95) begin
                    if (txd === 1'b1) mon_finish(0);
                    else if (m_data == 8'h00) m_brk = 1;
                    else begin
                        chk("mon_stop_bit", 32'(txd), 32'd1);
                        m_active = 0;
                    end
                end
            end else if (txd === 1'b1) begin
                mon_finish(1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (!(exp_q.size() == 0 && busy === 1'b0 && fifo_count === 3'd0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < limit), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_txd", 32'(txd), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(tx_ready), 32'd1);
        chk("reset_count", 32'(fifo_count), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single byte latency and busy duration
        expect_item(0, 8'hA5, -1);
        push(8'hA5);
        chk("t1_txd_at_accept", 32'(txd), 32'd1);
        @(negedge clk);
        chk("t1_txd_start", 32'(txd), 32'd0);
        chk("t1_busy_rise", 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("t1_busy_cycles", 32'(n), 32'd100);
        wait_idle("t1_idle", 500);

        // 2: fill while disabled, overflow drop, then drain back-to-back
        en = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            tx_data  = 8'(i);
            tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        chk("t2_count_full", 32'(fifo_count), 32'd4);
        chk("t2_ready_full", 32'(tx_ready), 32'd0);
        expect_item(0, 8'h01, -1);
        expect_item(0, 8'h02, 101);
        expect_item(0, 8'h03, 101);
        expect_item(0, 8'h04, 101);
        en = 1'b1;
        @(negedge clk);
        chk("t2_ready_after_pop", 32'(tx_ready), 32'd1);
        chk("t2_count_after_pop", 32'(fifo_count), 32'd3);
        wait_idle("t2_idle", 1000);

        // 3: BREAK requested mid-frame waits for frame end, precedes queued byte
        expect_item(0, 8'h5A, -1);
        expect_item(1, 8'h00, 101);
        expect_item(0, 8'h3C, 111);
        push(8'h5A);
        push(8'h3C);
        repeat (28) @(negedge clk);
        tx_break = 1'b1;
        @(negedge clk);
        tx_break = 1'b0;
        wait_idle("t3_idle", 1000);

        // 6: disable mid-frame; in-flight frame completes, queue holds
        expect_item(0, 8'h11, -1);
        expect_item(0, 8'h22, -1);
        push(8'h11);
        push(8'h22);
        repeat (40) @(negedge clk);
        en = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("t6_frame_completes", 32'(n < 200), 32'd1);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (txd !== 1'b1) n++;
        end
        chk("t6_line_idle_low_samples", 32'(n), 32'd0);
        chk("t6_count_held", 32'(fifo_count), 32'd1);
        chk("t6_busy_low", 32'(busy), 32'd0);
        en = 1'b1;
        @(negedge clk);
        chk("t6_restart_txd", 32'(txd), 32'd0);
        chk("t6_restart_busy", 32'(busy), 32'd1);
        wait_idle("t6_idle", 500);

        // 4: asynchronous reset mid-frame
        push(8'h77);
        push(8'h66);
        repeat (44) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t4_txd_async", 32'(txd), 32'd1);
        chk("t4_busy_async", 32'(busy), 32'd0);
        chk("t4_count_async", 32'(fifo_count), 32'd0);
        chk("t4_ready_async", 32'(tx_ready), 32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        n = 0;
        repeat (150) begin
            @(negedge clk);
            if (txd !== 1'b1) n++;
        end
        chk("t4_no_resume_low_samples", 32'(n), 32'd0);
        chk("t4_count_after", 32'(fifo_count), 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered UART transmitter: the transmit-direction counterpart of the existing UART receive path. It accepts bytes over a valid/ready handshake into a small FIFO and serialises each one as an 8N1-style frame on `uart_txd`. It can also emit a BREAK condition on request. It sits beside the receiver in the wrapper and returns status and readback bytes to the host over the same line rate.

## Interface
Parameters:
- `BIT_RATE`, 9600: line rate in bits/s.
- `CLK_HZ`, 50000000: frequency of `clk` in Hz.
- `PAYLOAD_BITS`, 8: data bits per frame.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 4: byte FIFO entries; must be a power of 2, minimum 2.

Derived value:
- `CPB = CLK_HZ / BIT_RATE`, truncating integer division. With the defaults, `CPB` = 5208.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `uart_tx_en`, input, 1: transmit enable. Gates the start of new frames only.
- `uart_tx_data`, input, `PAYLOAD_BITS`: byte to enqueue.
- `uart_tx_valid`, input, 1: `uart_tx_data` is valid.
- `uart_tx_ready`, output, 1: FIFO can accept a byte. Equal to FIFO not full.
- `uart_tx_break`, input, 1: single-cycle BREAK request.
- `uart_txd`, output, 1: serial line, registered, idle high.
- `uart_tx_busy`, output, 1: a frame or BREAK is in progress.
- `fifo_count`, output, log2(`FIFO_DEPTH`)+1: number of bytes currently queued.

## Operation
- Enqueue happens on any edge where `uart_tx_valid` and `uart_tx_ready` are both 1. A write while full is dropped silently.
- A push and a pop on the same edge leave `fifo_count` unchanged.
- Pending BREAK:
  - A `uart_tx_break` pulse sets a sticky `brk_pend` flag.
  - Pulses that arrive while `brk_pend` is already set are merged into it.
  - `brk_pend` is cleared when the BREAK state is entered.
- State machine states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - `uart_txd` = 1 and `uart_tx_busy` = 0.
  - If `uart_tx_en` = 1 and `brk_pend` = 1, go to BREAK. BREAK has priority over FIFO data.
  - Otherwise, if `uart_tx_en` = 1 and the FIFO is non-empty, pop the head byte into a shift register and go to START.
- START: `uart_txd` = 0 for `CPB` cycles, then go to DATA.
- DATA:
  - Shift out `PAYLOAD_BITS` bits, LSB first, each held for `CPB` cycles.
  - A bit counter counts 0 to `PAYLOAD_BITS`-1; then go to STOP.
- STOP: `uart_txd` = 1 for `STOP_BITS`*`CPB` cycles, then go to IDLE.
- BREAK: `uart_txd` = 0 for (1+`PAYLOAD_BITS`+`STOP_BITS`)*`CPB` cycles, then `uart_txd` = 1 for `STOP_BITS`*`CPB` cycles, then go to IDLE.
- Dropping `uart_tx_en` mid-frame does not stop the frame; it completes. No new frame or BREAK starts while `uart_tx_en` = 0. FIFO writes are still accepted.
- The cycle counter is wide enough for `CPB`*(1+`PAYLOAD_BITS`+`STOP_BITS`). It resets to 0 at every state change.
- Reset, including mid-frame, takes effect immediately and asynchronously:
  - `uart_txd` = 1, `uart_tx_busy` = 0, `uart_tx_ready` = 1, `fifo_count` = 0.
  - FIFO is flushed, `brk_pend` = 0, state = IDLE.

## Timing
- A byte accepted at edge N into an empty FIFO, with the FSM in IDLE: pop and START entry at edge N+1, so `uart_txd` falls at edge N+1.
- `uart_tx_busy` rises at edge N+1 and falls at the edge where IDLE is re-entered.
- Frame length is (1+`PAYLOAD_BITS`+`STOP_BITS`)*`CPB` cycles. Back-to-back frames are separated by exactly 1 idle cycle with `uart_txd` = 1.
- `uart_tx_ready` is combinational from the FIFO count. When the FIFO is full, it rises in the cycle after the pop edge.
- A BREAK request made while a frame is in flight starts 1 cycle after that frame's STOP ends.

## Test plan
Directed scenarios 1–4 use `CLK_HZ`=1000 and `BIT_RATE`=100, giving `CPB`=10.
1. Push 0xA5 at edge N while idle, `uart_tx_en`=1 -> `uart_txd` is 0 over edges N+1..N+10, then bits 1,0,1,0,0,1,0,1 for 10 cycles each, then high. `uart_tx_busy` is high for exactly 100 cycles.
2. With `uart_tx_en`=0, push 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive edges:
   - `fifo_count`=4, `uart_tx_ready`=0, and 0x05 is dropped.
   - Then set `uart_tx_en`=1 -> four frames 0x01..0x04 with a 1-cycle gap between frames; `uart_tx_ready` returns to 1 one cycle after the first pop.
3. Pulse `uart_tx_break` at frame cycle 30 of 0x5A with 0x3C queued:
   - 0x5A completes.
   - Then 1 idle cycle, then `uart_txd` low for 100 cycles and high for 10 cycles.
   - Then 1 idle cycle, then the 0x3C frame.
4. Assert `rst` at cycle 45 of a frame -> `uart_txd`=1 within the same cycle, FIFO empty, `uart_tx_busy`=0. No frame resumes after `rst` is released.
5. Default parameters, looped back into the receiver wrapper: send 0x13, 0x01, 0x01, 0xF9 -> the receiver reports those four bytes in order with `uart_rx_valid` and no break.
6. Drop `uart_tx_en` in the middle of frame 1 with 2 bytes queued -> frame 1 completes, `uart_txd` stays high, `fifo_count` stays 1. Re-enabling starts the next frame on the following edge.
